systolic_mm_top: RTL and testbench
==================================

// Module: systolic_mm_top
// PURPOSE
//   Matrix-multiply engine: C[MAT_N x MAT_M] = A[MAT_N x MAT_K] * B[MAT_K x MAT_M], signed operands.
//   Loads A and B as word streams into on-chip buffers and computes C tile-by-tile on a
//   PE_ROWS x PE_COLS output-stationary systolic PE array. Streams C out row-major.
//   Top-level compute block of the accelerator, fed and drained by the host/DMA side.
// PARAMETERS
//   DATA_WIDTH 16  operand and output word width (signed two's complement)
//   PE_ROWS    4   PE array rows (C tile height); MAT_N must be a multiple of it
//   PE_COLS    4   PE array columns (C tile width); MAT_M must be a multiple of it
//   MAT_N      64  rows of A and C
//   MAT_K      64  columns of A = rows of B (reduction length)
//   MAT_M      64  columns of B and C
// PORTS
//   clk          in   1           single clock, all logic on rising edge
//   rst_n        in   1           asynchronous, active-low reset
//   start        in   1           1-cycle pulse: begin a new job (honoured only in IDLE or DONE)
//   done         out  1           high from end of compute until the next accepted start
//   din_a        in   DATA_WIDTH  A element, row-major (index r*MAT_K+k)
//   din_a_valid  in   1           din_a carries a valid element this cycle
//   din_b        in   DATA_WIDTH  B element, row-major (index k*MAT_M+c)
//   din_b_valid  in   1           din_b carries a valid element this cycle
//   dout_c       out  DATA_WIDTH  C element, row-major (index r*MAT_M+c)
//   dout_c_valid out  1           dout_c valid this cycle
// BEHAVIOUR
//   Reset (async assert): state=IDLE, done=0, dout_c=0, dout_c_valid=0, all counters and PE accumulators 0.
//   Reset mid-job aborts the job. No partial output. Buffer contents are don't-care.
//   FSM: IDLE -start-> LOAD -both buffers full-> COMPUTE -last tile written-> OUTPUT -> DONE.
//   start in LOAD/COMPUTE/OUTPUT is ignored. start in DONE clears done and enters LOAD.
//   LOAD: independent A and B write counters. Every cycle with *_valid=1 writes one word, no backpressure.
//     Beats may begin the cycle after start. A and B may be sent sequentially or interleaved.
//     Beats beyond MAT_N*MAT_K (A) or MAT_K*MAT_M (B) are dropped. Valid beats outside LOAD are ignored.
//   COMPUTE: for each C tile (tile rows outer, tile cols inner), clear the PE accumulators.
//     Feed row i of A skewed by i cycles and column j of B skewed by j cycles.
//     PE(i,j) does acc += a*b and forwards a right and b down with 1-cycle registers.
//     After MAT_K + PE_ROWS + PE_COLS - 2 cycles, write the tile into the C buffer.
//   Arithmetic: product 2*DATA_WIDTH signed. Accumulator ACC_W = 2*DATA_WIDTH + clog2(MAT_K), never overflows.
//     dout_c = acc[DATA_WIDTH-1:0] (wrap, no saturation).
//   OUTPUT: done rises on entry. Starting the next cycle, dout_c_valid=1 for exactly MAT_N*MAT_M
//     consecutive cycles, one C element per cycle in row-major order, no gaps.
//     Then dout_c_valid=0 and dout_c holds. State becomes DONE, done stays 1.
//   done and dout_c_valid are registered outputs.
// TESTING
//   1 Reset: hold rst_n=0 10 cycles -> done=0, dout_c_valid=0, dout_c=0. Assert rst_n async mid-OUTPUT -> valid drops immediately.
//   2 Identity: A=I(64), B[k][c]=k*64+c -> C equals B. Exactly 4096 contiguous valid beats, row-major, after done rises.
//   3 Random signed: A,B in [-128,127], 64x64x64 -> every dout_c equals low 16 bits of the golden int32 C, including negatives.
//   4 Overflow wrap: all A=B=16'h7FFF -> every C = 64*0x3FFF0001, dout_c = 16'h0040 for all 4096 beats.
//   5 Protocol: A and B interleaved with random idle gaps, 10 extra A beats, start pulsed during COMPUTE
//     -> result identical to test 3, extra beats and stray start ignored.
//   6 Back-to-back: second start in DONE with new A,B -> done clears next cycle, second result correct, no stale data.

Source files
------------

// File: rtl/systolic_mm_top.sv
// systolic_mm_top: buffered A*B matrix multiply on an output-stationary PE array.
// Loads A and B, computes C tile by tile, then streams C out row-major.
module systolic_mm_top #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_ROWS    = 4,
  parameter int PE_COLS    = 4,
  parameter int MAT_N      = 64,
  parameter int MAT_K      = 64,
  parameter int MAT_M      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  din_a_valid,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  din_b_valid,
  output logic [DATA_WIDTH-1:0] dout_c,
  output logic                  dout_c_valid
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(MAT_K);
  localparam int NA    = MAT_N*MAT_K;
  localparam int NB    = MAT_K*MAT_M;
  localparam int NC    = MAT_N*MAT_M;
  localparam int AAW   = $clog2(NA);
  localparam int BAW   = $clog2(NB);
  localparam int CAW   = $clog2(NC);
  localparam int LAST  = MAT_K + PE_ROWS + PE_COLS - 2;
  localparam int TR    = MAT_N/PE_ROWS;
  localparam int TC    = MAT_M/PE_COLS;
  localparam int CW    = $clog2(LAST+1);
  localparam int TRW   = $clog2(TR+1);
  localparam int TCW   = $clog2(TC+1);

  localparam logic [AAW:0]   A_FULL   = (AAW+1)'(NA);
  localparam logic [BAW:0]   B_FULL   = (BAW+1)'(NB);
  localparam logic [CAW:0]   C_LAST   = (CAW+1)'(NC-1);
  localparam logic [CW-1:0]  CYC_LAST = CW'(LAST);
  localparam logic [TRW-1:0] TR_LAST  = TRW'(TR-1);
  localparam logic [TCW-1:0] TC_LAST  = TCW'(TC-1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_COMP = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]     state;
  logic [AAW:0]   a_cnt;
  logic [BAW:0]   b_cnt;
  logic [CAW:0]   o_cnt;
  logic [CW-1:0]  cyc;
  logic [TRW-1:0] tr;
  logic [TCW-1:0] tc;

  logic [DATA_WIDTH-1:0] a_buf [NA];
  logic [DATA_WIDTH-1:0] b_buf [NB];
  logic [DATA_WIDTH-1:0] c_buf [NC];

  logic signed [DATA_WIDTH-1:0] a_feed [PE_ROWS];
  logic signed [DATA_WIDTH-1:0] b_feed [PE_COLS];
  logic signed [DATA_WIDTH-1:0] a_h [PE_ROWS][PE_COLS];
  logic signed [DATA_WIDTH-1:0] b_v [PE_ROWS][PE_COLS];
  logic signed [ACC_W-1:0]      acc [PE_ROWS][PE_COLS];

  logic comp, tile_end, last_tile, a_full, b_full;

  assign comp      = (state == S_COMP);
  assign tile_end  = comp && (cyc == CYC_LAST);
  assign last_tile = (tr == TR_LAST) && (tc == TC_LAST);
  assign a_full    = (a_cnt == A_FULL);
  assign b_full    = (b_cnt == B_FULL);

  // Skewed edge feeds: row i lags by i cycles, column j by j cycles.
  always_comb begin
    for (int i = 0; i < PE_ROWS; i++) begin
      a_feed[i] = '0;
      if (comp && int'(cyc) >= i && int'(cyc) - i < MAT_K)
        a_feed[i] = a_buf[AAW'((int'(tr)*PE_ROWS + i)*MAT_K
                               + int'(cyc) - i)];
    end
    for (int j = 0; j < PE_COLS; j++) begin
      b_feed[j] = '0;
      if (comp && int'(cyc) >= j && int'(cyc) - j < MAT_K)
        b_feed[j] = b_buf[BAW'((int'(cyc) - j)*MAT_M
                               + int'(tc)*PE_COLS + j)];
    end
  end

  for (genvar i = 0; i < PE_ROWS; i++) begin : g_row
    for (genvar j = 0; j < PE_COLS; j++) begin : g_col
      logic signed [DATA_WIDTH-1:0]   a_in, b_in, a_q, b_q;
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_W-1:0]        acc_q;

      if (j == 0) begin : g_al
        assign a_in = a_feed[i];
      end else begin : g_ai
        assign a_in = a_h[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign b_in = b_feed[j];
      end else begin : g_bi
        assign b_in = b_v[i-1][j];
      end

      assign prod      = a_in * b_in;
      assign a_h[i][j] = a_q;
      assign b_v[i][j] = b_q;
      assign acc[i][j] = acc_q;

      // PE: MAC and forward operands; cleared as its tile is written out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (comp) begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= tile_end ? '0 : acc_q + prod;
        end
      end
    end
  end

  // Operand buffers fill while loading; excess beats fall off the end.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && din_a_valid && !a_full)
      a_buf[a_cnt[AAW-1:0]] <= din_a;
    if (state == S_LOAD && din_b_valid && !b_full)
      b_buf[b_cnt[BAW-1:0]] <= din_b;
  end

  // Finished tile lands in the C buffer at its row-major slots.
  always_ff @(posedge clk) begin
    if (tile_end) begin
      for (int i = 0; i < PE_ROWS; i++)
        for (int j = 0; j < PE_COLS; j++)
          c_buf[CAW'((int'(tr)*PE_ROWS + i)*MAT_M
                     + int'(tc)*PE_COLS + j)]
            <= acc[i][j][DATA_WIDTH-1:0];
    end
  end

  // Job sequencer: load, tile walk, output stream, done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      done         <= 1'b0;
      dout_c       <= '0;
      dout_c_valid <= 1'b0;
      a_cnt        <= '0;
      b_cnt        <= '0;
      o_cnt        <= '0;
      cyc          <= '0;
      tr           <= '0;
      tc           <= '0;
    end else begin
      dout_c_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_LOAD;
            done  <= 1'b0;
            a_cnt <= '0;
            b_cnt <= '0;
            o_cnt <= '0;
            cyc   <= '0;
            tr    <= '0;
            tc    <= '0;
          end
        end
        S_LOAD: begin
          if (din_a_valid && !a_full) a_cnt <= a_cnt + 1'b1;
          if (din_b_valid && !b_full) b_cnt <= b_cnt + 1'b1;
          if (a_full && b_full) state <= S_COMP;
        end
        S_COMP: begin
          if (tile_end) begin
            cyc <= '0;
            if (tc == TC_LAST) begin
              tc <= '0;
              tr <= tr + 1'b1;
            end else begin
              tc <= tc + 1'b1;
            end
            if (last_tile) begin
              state <= S_OUT;
              done  <= 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_OUT: begin
          dout_c       <= c_buf[o_cnt[CAW-1:0]];
          dout_c_valid <= 1'b1;
          o_cnt        <= o_cnt + 1'b1;
          if (o_cnt == C_LAST) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm_top.sv
// tb_systolic_mm_top: random and directed jobs against a plain
// matrix-product reference, checked through an output scoreboard.
module tb_systolic_mm_top;

  localparam int DW = 16;
  localparam int PR = 4;
  localparam int PC = 4;
  localparam int N  = 8;
  localparam int K  = 64;
  localparam int M  = 12;
  localparam int NA = N*K;
  localparam int NB = K*M;
  localparam int NC = N*M;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          done;
  logic [DW-1:0] din_a;
  logic          din_a_valid;
  logic [DW-1:0] din_b;
  logic          din_b_valid;
  logic [DW-1:0] dout_c;
  logic          dout_c_valid;

  always #5 clk = ~clk;

  systolic_mm_top #(
    .DATA_WIDTH(DW), .PE_ROWS(PR), .PE_COLS(PC),
    .MAT_N(N), .MAT_K(K), .MAT_M(M)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .din_a(din_a), .din_a_valid(din_a_valid),
    .din_b(din_b), .din_b_valid(din_b_valid),
    .dout_c(dout_c), .dout_c_valid(dout_c_valid)
  );

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_exp;
  longint        am [N][K];
  longint        bm [K][M];

  task automatic chk(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every valid output beat is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && dout_c_valid) begin
      if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
      else chk("dout_c", dout_c, exp_q.pop_front());
    end
  end

  function automatic longint rnd8();
    return longint'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < N; r++)
      for (int k = 0; k < K; k++)
        case (kind)
          0:       am[r][k] = (r == k) ? 1 : 0;
          1:       am[r][k] = rnd8();
          default: am[r][k] = 32767;
        endcase
    for (int k = 0; k < K; k++)
      for (int c = 0; c < M; c++)
        case (kind)
          0:       bm[k][c] = k*M + c;
          1:       bm[k][c] = rnd8();
          default: bm[k][c] = 32767;
        endcase
  endtask

  task automatic push_expected();
    longint s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) begin
        s = 0;
        for (int k = 0; k < K; k++) s += am[r][k] * bm[k][c];
        exp_q.push_back(s[DW-1:0]);
        last_exp = s[DW-1:0];
      end
  endtask

  task automatic load_job(input int kind, input bit inter,
                          input int extra_a, input bit stray);
    int ia, ib;
    bit pa, pb, sa, sb;
    fill(kind);
    push_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_clear", done, 0);
    ia = 0;
    ib = 0;
    while (ia < NA + extra_a || ib < NB) begin
      pa = ia < NA + extra_a;
      pb = ib < NB;
      sa = pa && (!inter || $urandom_range(0, 2) != 0);
      sb = pb && (inter ? ($urandom_range(0, 2) != 0) : !pa);
      din_a_valid = sa;
      din_b_valid = sb;
      din_a = DW'($urandom);
      din_b = DW'($urandom);
      if (sa && ia < NA) din_a = am[ia/K][ia%K][DW-1:0];
      if (sb) din_b = bm[ib/M][ib%M][DW-1:0];
      if (sa) ia++;
      if (sb) ib++;
      @(negedge clk);
    end
    din_a_valid = 1'b0;
    din_b_valid = 1'b0;
    if (stray) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int i = 0;
    while (!done && i < 20000) begin
      @(negedge clk);
      i++;
    end
    chk("done_rise", done, 1);
  endtask

  task automatic drain_job();
    int i, n;
    wait_done();
    if (!done) begin
      exp_q.delete();
      return;
    end
    chk("valid_before_done", dout_c_valid, 0);
    i = 0;
    while (!dout_c_valid && i < 5) begin
      @(negedge clk);
      i++;
    end
    n = 0;
    while (dout_c_valid && n < NC + 8) begin
      n++;
      @(negedge clk);
    end
    chk("beat_count", n, NC);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_hold", done, 1);
    chk("dout_hold", dout_c, last_exp);
    exp_q.delete();
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    din_a       = '0;
    din_b       = '0;
    din_a_valid = 1'b0;
    din_b_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_valid", dout_c_valid, 0);
    chk("rst_dout", dout_c, 0);
    rst_n = 1'b1;
    @(negedge clk);

    load_job(0, 1'b0, 0, 1'b0);
    drain_job();
    load_job(1, 1'b0, 0, 1'b0);
    drain_job();
    load_job(2, 1'b0, 0, 1'b0);
    drain_job();
    load_job(1, 1'b1, 10, 1'b1);
    drain_job();
    load_job(1, 1'b1, 0, 1'b0);
    drain_job();

    load_job(1, 1'b0, 0, 1'b0);
    wait_done();
    repeat (6) @(negedge clk);
    chk("mid_output_valid", dout_c_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", dout_c_valid, 0);
    chk("async_done", done, 0);
    chk("async_dout", dout_c, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_valid", dout_c_valid, 0);
    chk("post_reset_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
